vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised, runtime-reprogrammable VGA timing generator that drives a vga_if-style output stream (hcount, vcount, syncs, blanks, rgb = 0). It adds a pixel clock enable, configurable sync polarity, data-enable, and start-of-frame/start-of-line strobes. It also adds a shadowed configuration port, so resolution changes take effect only at a frame boundary. It sits at the head of the video pipeline and feeds the draw/overlay stages.

Parameters:
CNT_W, 12, width of hcount/vcount and all cfg fields
H_ACTIVE, 1024, reset-default visible pixels per line
H_FP, 24, reset-default horizontal front porch
H_SYNC, 136, reset-default hsync width
H_BP, 160, reset-default horizontal back porch (total 1344)
V_ACTIVE, 768, reset-default visible lines
V_FP, 3, reset-default vertical front porch
V_SYNC, 6, reset-default vsync width
V_BP, 29, reset-default vertical back porch (total 806)
HS_POL, 1, hsync active level
VS_POL, 1, vsync active level

Ports:
clk  in  1  pixel-domain clock
rst  in  1  synchronous, active-high reset
en  in  1  pixel clock enable; generator advances only when 1
cfg_wr  in  1  one-cycle strobe: load cfg_* fields into pending shadow
cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp  in  CNT_W each  horizontal timing request
cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp  in  CNT_W each  vertical timing request
cfg_pending  out  1  shadow holds an unapplied configuration
cfg_err  out  1  one-cycle pulse: last cfg_wr rejected
hcount  out  CNT_W  current pixel column
vcount  out  CNT_W  current line
hsync  out  1  horizontal sync, level per HS_POL
vsync  out  1  vertical sync, level per VS_POL
hblnk  out  1  horizontal blanking
vblnk  out  1  vertical blanking
de  out  1  data enable = !hblnk && !vblnk
sof  out  1  one-cycle strobe coincident with output position (0,0)
sol  out  1  one-cycle strobe coincident with hcount == 0
rgb  out  12  driven 0 always

Behaviour:
- Reset (rst=1 on a clk edge): active timing set = parameter defaults; shadow cleared; cfg_pending=0; cfg_err=0; hcount=vcount=0; hblnk=vblnk=0; de=1; hsync=!HS_POL; vsync=!VS_POL; sof=sol=0; rgb=0. Reset mid-frame or mid-update discards any pending config.
- All outputs are registered and decoded from the next-state counters, so syncs, blanks, de and counts are mutually aligned with zero skew.
- Totals: HT = h_active+h_fp+h_sync+h_bp; VT likewise. Sums use CNT_W+2 bits.
- en=1: hcount increments. At hcount==HT-1 it wraps to 0 and vcount increments. At vcount==VT-1 with the hcount wrap, vcount wraps to 0.
- en=0: all outputs hold, except sof/sol, which drop to 0. Strobes fire only on enabled advances.
- hblnk=1 iff hcount >= h_active. hsync is at the active level iff h_active+h_fp <= hcount < h_active+h_fp+h_sync. Vertical decoding is identical on vcount.
- sol=1 on each advance to hcount=0. sof=1 on the advance to (0,0). sof implies sol.
- Config validation on cfg_wr:
  - Reject if any of h_active, h_sync, v_active or v_sync is 0, or if HT or VT > 2^CNT_W.
  - Rejected write: cfg_err pulses 1 cycle later, shadow and cfg_pending are unchanged.
  - Accepted write: overwrites the shadow (last write wins), and cfg_pending=1 next cycle.
- Apply point: the enabled advance to (0,0) while cfg_pending=1. The outputs at that (0,0) are already decoded with the new set. cfg_pending clears in the same cycle.
- cfg_wr in the same cycle as the apply point: the apply uses the previous shadow, the new write becomes pending for the following frame, and cfg_pending stays 1.
- Counters never exceed the active totals, because timing changes only at wrap.

Test Plan:
1. Defaults, en=1 for 2 frames -> hcount 0..1343, vcount 0..805; hsync=1 exactly for hcount 1048..1183; vsync=1 for lines 771..776; hblnk from 1024; vblnk from 768; sof spacing 1083264 cycles; sol spacing 1344.
2. en toggled 1/0 alternately -> outputs hold on en=0 cycles; sof spacing 2166528 cycles; no strobe on held cycles.
3. Mid-frame cfg_wr of 640/16/96/48 x 480/10/2/33 -> cfg_pending=1; current frame finishes at 1344x806; next frame HT=800, VT=525, hsync on hcount 656..751; cfg_pending clears at that sof.
4. cfg_wr with cfg_h_sync=0, and a separate write with HT=5000 (CNT_W=12) -> each gives a cfg_err pulse; timing is unchanged; cfg_pending stays 0.
5. Two cfg_wr writes before the frame end, plus a third write on the apply cycle -> second config applied; third config pending; applied at the next frame.
6. rst asserted at hcount=500, vcount=300, with a config pending -> next cycle all reset values; defaults are restored; cfg_pending=0. Separately, with HS_POL=0 and VS_POL=0 -> syncs are inverted over the same windows.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA timing generator with pixel enable, programmable sync polarity and a
// shadowed timing set that is swapped in only at the start of a frame.
module vga_timing_gen #(
  parameter int CNT_W    = 12,
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_wr,
  input  logic [CNT_W-1:0] cfg_h_active,
  input  logic [CNT_W-1:0] cfg_h_fp,
  input  logic [CNT_W-1:0] cfg_h_sync,
  input  logic [CNT_W-1:0] cfg_h_bp,
  input  logic [CNT_W-1:0] cfg_v_active,
  input  logic [CNT_W-1:0] cfg_v_fp,
  input  logic [CNT_W-1:0] cfg_v_sync,
  input  logic [CNT_W-1:0] cfg_v_bp,
  output logic             cfg_pending,
  output logic             cfg_err,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             de,
  output logic             sof,
  output logic             sol,
  output logic [11:0]      rgb
);

  localparam int SW = CNT_W + 2;
  localparam logic [SW-1:0] MAX_TOTAL = SW'(1) << CNT_W;

  typedef struct packed {
    logic [CNT_W-1:0] h_active, h_fp, h_sync, h_bp;
    logic [CNT_W-1:0] v_active, v_fp, v_sync, v_bp;
  } timing_t;

  localparam timing_t DEFAULTS = '{
    h_active: CNT_W'(H_ACTIVE), h_fp: CNT_W'(H_FP), h_sync: CNT_W'(H_SYNC), h_bp: CNT_W'(H_BP),
    v_active: CNT_W'(V_ACTIVE), v_fp: CNT_W'(V_FP), v_sync: CNT_W'(V_SYNC), v_bp: CNT_W'(V_BP)
  };

  function automatic logic [SW-1:0] ext(input logic [CNT_W-1:0] x);
    return {2'b00, x};
  endfunction

  timing_t act_reg, shd_reg, cfg_in, nxt_set;
  logic [SW-1:0] ht, vt, cfg_ht, cfg_vt;
  logic [SW-1:0] hs_start, hs_stop, vs_start, vs_stop;
  logic [CNT_W-1:0] h_next, v_next;
  logic h_wrap, v_wrap, apply, cfg_ok;
  logic hs_act, vs_act, hb_next, vb_next;

  assign cfg_in = '{
    h_active: cfg_h_active, h_fp: cfg_h_fp, h_sync: cfg_h_sync, h_bp: cfg_h_bp,
    v_active: cfg_v_active, v_fp: cfg_v_fp, v_sync: cfg_v_sync, v_bp: cfg_v_bp
  };

  always_comb begin
    ht     = ext(act_reg.h_active) + ext(act_reg.h_fp) + ext(act_reg.h_sync) + ext(act_reg.h_bp);
    vt     = ext(act_reg.v_active) + ext(act_reg.v_fp) + ext(act_reg.v_sync) + ext(act_reg.v_bp);
    cfg_ht = ext(cfg_in.h_active) + ext(cfg_in.h_fp) + ext(cfg_in.h_sync) + ext(cfg_in.h_bp);
    cfg_vt = ext(cfg_in.v_active) + ext(cfg_in.v_fp) + ext(cfg_in.v_sync) + ext(cfg_in.v_bp);
  end

  assign cfg_ok = (cfg_in.h_active != '0) && (cfg_in.h_sync != '0) &&
                  (cfg_in.v_active != '0) && (cfg_in.v_sync != '0) &&
                  (cfg_ht <= MAX_TOTAL) && (cfg_vt <= MAX_TOTAL);

  assign h_wrap = (ext(hcount) == ht - SW'(1));
  assign v_wrap = (ext(vcount) == vt - SW'(1));
  assign apply  = en && h_wrap && v_wrap && cfg_pending;

  // The shadow set becomes active on the same edge that lands on (0,0),
  // so the first pixel of the new frame is already decoded with it.
  assign nxt_set = apply ? shd_reg : act_reg;

  always_comb begin
    h_next = hcount + CNT_W'(1);
    v_next = vcount;
    if (h_wrap) begin
      h_next = '0;
      v_next = v_wrap ? '0 : vcount + CNT_W'(1);
    end
  end

  always_comb begin
    hs_start = ext(nxt_set.h_active) + ext(nxt_set.h_fp);
    hs_stop  = hs_start + ext(nxt_set.h_sync);
    vs_start = ext(nxt_set.v_active) + ext(nxt_set.v_fp);
    vs_stop  = vs_start + ext(nxt_set.v_sync);
    hs_act   = (ext(h_next) >= hs_start) && (ext(h_next) < hs_stop);
    vs_act   = (ext(v_next) >= vs_start) && (ext(v_next) < vs_stop);
    hb_next  = (h_next >= nxt_set.h_active);
    vb_next  = (v_next >= nxt_set.v_active);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_reg     <= DEFAULTS;
      shd_reg     <= '0;
      cfg_pending <= 1'b0;
      cfg_err     <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      de          <= 1'b1;
      sof         <= 1'b0;
      sol         <= 1'b0;
    end else begin
      cfg_err <= cfg_wr && !cfg_ok;
      // A write landing on the apply edge wins over the clear.
      if (cfg_wr && cfg_ok) begin
        shd_reg     <= cfg_in;
        cfg_pending <= 1'b1;
      end else if (apply) begin
        cfg_pending <= 1'b0;
      end
      if (en) begin
        act_reg <= nxt_set;
        hcount  <= h_next;
        vcount  <= v_next;
        hsync   <= hs_act ? HS_POL : ~HS_POL;
        vsync   <= vs_act ? VS_POL : ~VS_POL;
        hblnk   <= hb_next;
        vblnk   <= vb_next;
        de      <= !hb_next && !vb_next;
        sol     <= (h_next == '0);
        sof     <= (h_next == '0) && (v_next == '0);
      end else begin
        sof <= 1'b0;
        sol <= 1'b0;
      end
    end
  end

  assign rgb = 12'h000;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a small-timing instance is walked through
// frames, holds, reconfiguration and reset; a full-size instance checks inverted syncs.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst, en, en2, cfg_wr;
  logic [11:0] cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp;
  logic [11:0] cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp;
  logic cfg_pending, cfg_err, hsync, vsync, hblnk, vblnk, de, sof, sol;
  logic [11:0] hcount, vcount, rgb;
  logic n_pending, n_err, n_hsync, n_vsync, n_hblnk, n_vblnk, n_de, n_sof, n_sol;
  logic [11:0] n_hcount, n_vcount, n_rgb;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_wr(cfg_wr),
    .cfg_h_active(cfg_h_active), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
    .cfg_v_active(cfg_v_active), .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
    .cfg_pending(cfg_pending), .cfg_err(cfg_err), .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .hblnk(hblnk), .vblnk(vblnk), .de(de),
    .sof(sof), .sol(sol), .rgb(rgb)
  );

  vga_timing_gen #(.HS_POL(1'b0), .VS_POL(1'b0)) dut_neg (
    .clk(clk), .rst(rst), .en(en2), .cfg_wr(1'b0),
    .cfg_h_active(12'd0), .cfg_h_fp(12'd0), .cfg_h_sync(12'd0), .cfg_h_bp(12'd0),
    .cfg_v_active(12'd0), .cfg_v_fp(12'd0), .cfg_v_sync(12'd0), .cfg_v_bp(12'd0),
    .cfg_pending(n_pending), .cfg_err(n_err), .hcount(n_hcount), .vcount(n_vcount),
    .hsync(n_hsync), .vsync(n_vsync), .hblnk(n_hblnk), .vblnk(n_vblnk), .de(n_de),
    .sof(n_sof), .sol(n_sol), .rgb(n_rgb)
  );

  int n_checks = 0;
  int n_pass = 0;
  int dflt [8] = '{16, 2, 4, 3, 8, 1, 2, 2};
  int cur [8];
  int shd [8];
  int wr_val [8];
  int h, v, cyc, last_sof, exp_spacing;
  bit pend, wr_now, wr_ok;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d, h=%0d v=%0d)", tag, got, exp, cyc, h, v);
  endtask

  task automatic step(input bit e);
    bit apply, hs, vs, hb, vb, sol_e, sof_e, err_e;
    int ht, vt;
    en = e;
    cfg_wr = wr_now;
    @(posedge clk); #1;
    cyc++;
    apply = 1'b0;
    if (e) begin
      ht = cur[0] + cur[1] + cur[2] + cur[3];
      vt = cur[4] + cur[5] + cur[6] + cur[7];
      if (h == ht - 1) begin
        h = 0;
        if (v == vt - 1) begin v = 0; apply = pend; end
        else v++;
      end else h++;
    end
    if (apply) begin cur = shd; pend = 1'b0; end
    if (wr_now && wr_ok) begin shd = wr_val; pend = 1'b1; end
    err_e = wr_now && !wr_ok;
    wr_now = 1'b0;
    cfg_wr = 1'b0;
    hs = (h >= cur[0] + cur[1]) && (h < cur[0] + cur[1] + cur[2]);
    vs = (v >= cur[4] + cur[5]) && (v < cur[4] + cur[5] + cur[6]);
    hb = (h >= cur[0]);
    vb = (v >= cur[4]);
    sol_e = e && (h == 0);
    sof_e = sol_e && (v == 0);
    check("hcount", hcount, h);
    check("vcount", vcount, v);
    check("flags{hs,vs,hb,vb,de,sof,sol}", {hsync, vsync, hblnk, vblnk, de, sof, sol},
          {hs, vs, hb, vb, !hb && !vb, sof_e, sol_e});
    check("cfg_pending", cfg_pending, pend);
    check("cfg_err", cfg_err, err_e);
    if (sof_e && exp_spacing > 0) begin
      if (last_sof >= 0) check("sof_spacing", cyc - last_sof, exp_spacing);
      last_sof = cyc;
    end
  endtask

  task automatic write_cfg(input int ha, hf, hs, hb, va, vf, vs, vb, input bit ok);
    cfg_h_active = 12'(ha); cfg_h_fp = 12'(hf); cfg_h_sync = 12'(hs); cfg_h_bp = 12'(hb);
    cfg_v_active = 12'(va); cfg_v_fp = 12'(vf); cfg_v_sync = 12'(vs); cfg_v_bp = 12'(vb);
    wr_val = '{ha, hf, hs, hb, va, vf, vs, vb};
    wr_ok = ok;
    wr_now = 1'b1;
    step(1'b1);
    $display("cfg write %0d/%0d/%0d/%0d x %0d/%0d/%0d/%0d expect %s", ha, hf, hs, hb, va, vf, vs, vb,
             ok ? "accept" : "reject");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc++;
    cur = dflt; pend = 1'b0; h = 0; v = 0;
    check("rst_hcount", hcount, 0);
    check("rst_vcount", vcount, 0);
    check("rst_flags", {hsync, vsync, hblnk, vblnk, de, sof, sol}, 7'b0000100);
    check("rst_pending", cfg_pending, 0);
    check("rst_err", cfg_err, 0);
    check("rst_rgb", rgb, 0);
    $display("reset applied at cycle %0d", cyc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst = 1'b0; en = 1'b0; en2 = 1'b0; cfg_wr = 1'b0; wr_now = 1'b0; wr_ok = 1'b0;
    {cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp} = '0;
    {cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp} = '0;
    cyc = 0; last_sof = -1; exp_spacing = 0;
    @(posedge clk); #1;
    do_reset();

    // Defaults 25x13: three full frames, sof every 325 cycles.
    exp_spacing = 325; last_sof = -1;
    for (int i = 0; i < 976; i++) step(1'b1);
    $display("default frames done at h=%0d v=%0d", h, v);

    // Alternating enable: sof spacing doubles, held cycles carry no strobes.
    exp_spacing = 650; last_sof = -1;
    for (int i = 0; i < 1400; i++) step(i % 2 == 0);
    $display("enable toggle done at h=%0d v=%0d", h, v);
    exp_spacing = 0;

    // Mid-frame reconfiguration to 16x9 (hsync 11..13, vsync line 6).
    write_cfg(10, 1, 3, 2, 5, 1, 1, 2, 1'b1);
    for (int i = 0; i < 620; i++) step(1'b1);
    $display("reconfig frames done, pending=%0d", cfg_pending);

    // Rejected writes leave timing and pending untouched.
    write_cfg(16, 2, 0, 3, 8, 1, 2, 2, 1'b0);
    step(1'b1);
    write_cfg(4000, 500, 400, 100, 8, 1, 2, 2, 1'b0);
    write_cfg(8, 1, 1, 1, 4000, 50, 46, 1, 1'b0);
    write_cfg(8, 1, 1, 1, 0, 1, 1, 1, 1'b0);
    for (int i = 0; i < 160; i++) step(1'b1);

    // HT == 4096 is accepted, then overwritten; a third write lands on the apply edge.
    write_cfg(4000, 40, 50, 6, 1, 1, 1, 1, 1'b1);
    step(1'b1);
    write_cfg(6, 1, 2, 1, 3, 1, 1, 1, 1'b1);
    guard = 0;
    while (!(h == 15 && v == 8) && guard < 300) begin step(1'b1); guard++; end
    check("reach_apply_point", guard < 300, 1);
    write_cfg(8, 2, 2, 2, 4, 1, 2, 1, 1'b1);
    check("apply_edge_hcount", hcount, 0);
    check("apply_edge_pending", cfg_pending, 1);
    for (int i = 0; i < 180; i++) step(1'b1);
    $display("double-buffer sequence done, pending=%0d", cfg_pending);

    // Reset mid-frame with a config pending restores defaults.
    write_cfg(6, 1, 2, 1, 3, 1, 1, 1, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b1);
    do_reset();
    for (int i = 0; i < 340; i++) step(1'b1);

    // Full-size defaults with inverted syncs on the second instance.
    en = 1'b0;
    do_reset();
    check("neg_rst_syncs", {n_hsync, n_vsync, n_de}, 3'b111);
    en2 = 1'b1;
    for (int k = 1; k <= 1400; k++) begin
      int hc, vc;
      bit hs_in;
      @(posedge clk); #1;
      hc = k % 1344;
      vc = k / 1344;
      hs_in = (hc >= 1048) && (hc < 1184);
      check("neg_hcount", n_hcount, hc);
      check("neg_vcount", n_vcount, vc);
      check("neg_flags{hs,vs,hb,vb,de,sof,sol}", {n_hsync, n_vsync, n_hblnk, n_vblnk, n_de, n_sof, n_sol},
            {!hs_in, 1'b1, hc >= 1024, 1'b0, hc < 1024, 1'b0, hc == 0});
    end
    en2 = 1'b0;
    $display("inverted-polarity line scan done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
